pc_sequencer: RTL and testbench

- Parametrised, registered successor to the combinational next-PC logic in the single-cycle RISC-V core.
- Owns the architectural PC register and drives fetch through a valid/ready handshake.
- Resolves branches/JAL/JALR/AUIPC presented by execute, using corrected signed/unsigned flag semantics.
- Traps misaligned targets via a small FSM; sits between instruction memory and the execute stage.

---
 rtl/pc_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC sequencer sitting between instruction
// memory and execute. Owns the architectural PC, drives fetch with a
// valid/ready handshake, resolves branch/JAL/JALR redirects from execute and
// traps misaligned control-transfer targets.
//
// Optional feature: define PC_SEQ_PERF_CNT_EN to add the saturating
// performance counters perf_branches, perf_taken and perf_traps.
module pc_sequencer #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned      IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  // fetch side
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  // execute side
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu,
  input  logic            carry,
  input  logic            zero,
  input  logic            negative,
  input  logic            overflow,
  output logic            redirect,
  output logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] auipc_result,
  // trap side
  output logic            trap,
  output logic [XLEN-1:0] trap_epc,
  input  logic            trap_ack
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_taken,
  output logic [15:0]     perf_traps
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_epc_q, trap_epc_d;
  logic            fetch_valid_q, fetch_valid_d;

  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic            is_auipc;
  logic            signed_lt;
  logic            br_taken;
  logic            xfer;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            run_xfer;
  logic            trap_take;

  // Opcode decode of the execute-stage instruction
  always_comb begin
    is_branch = (ex_opcode == OP_BRANCH);
    is_jal    = (ex_opcode == OP_JAL);
    is_jalr   = (ex_opcode == OP_JALR);
    is_auipc  = (ex_opcode == OP_AUIPC);
  end

  // Branch condition from rs1-rs2 flags; carry=1 means no borrow (rs1 >= rs2 unsigned)
  always_comb begin
    signed_lt = negative ^ overflow;
    br_taken  = 1'b0;
    unique case (ex_func3)
      F3_BEQ:  br_taken = zero;
      F3_BNE:  br_taken = ~zero;
      F3_BLT:  br_taken = signed_lt;
      F3_BGE:  br_taken = ~signed_lt;
      F3_BLTU: br_taken = ~carry;
      F3_BGEU: br_taken = carry;
      default: br_taken = 1'b0;
    endcase
  end

  // Target generation and alignment check; all adds wrap modulo 2^XLEN
  always_comb begin
    br_target   = ex_pc + ex_imm;
    jalr_target = ex_alu & JALR_MASK;
    target      = is_jalr ? jalr_target : br_target;
    if (IALIGN == 32) begin
      misaligned = |target[1:0];
    end else begin
      misaligned = target[0];
    end
  end

  // Qualify the transfer: only live in RUN and never while reset is asserted
  always_comb begin
    xfer      = is_jal | is_jalr | (is_branch & br_taken);
    run_xfer  = ~rst & ex_valid & (state_q == ST_RUN) & xfer;
    redirect  = run_xfer & ~misaligned;
    trap_take = run_xfer & misaligned;
  end

  // Link and AUIPC results are always available from ex_pc
  always_comb begin
    link_addr    = ex_pc + PC_STEP;
    auipc_result = ex_pc + ex_imm;
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    trap_d     = trap_q;
    trap_epc_d = trap_epc_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trap_take) begin
          state_d    = ST_TRAP;
          pc_d       = TRAP_VECTOR;
          trap_d     = 1'b1;
          trap_epc_d = ex_pc;
        end else if (redirect) begin
          pc_d = target;
        end else if (fetch_ready) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_TRAP: begin
        pc_d = TRAP_VECTOR;
        if (trap_ack) begin
          state_d = ST_RUN;
          trap_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
        trap_d  = 1'b0;
      end
    endcase
    fetch_valid_d = (state_d == ST_RUN);
  end

  // State and architectural registers; reset wins over every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      trap_q        <= 1'b0;
      trap_epc_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_q        <= trap_d;
      trap_epc_q    <= trap_epc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign pc          = pc_q;
  assign trap        = trap_q;
  assign trap_epc    = trap_epc_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_taken_q;
  logic [15:0] perf_traps_q;
  logic        branch_evt;

  // A branch counts whenever execute presents one while running
  always_comb begin
    branch_evt = ~rst & ex_valid & (state_q == ST_RUN) & is_branch;
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
      perf_traps_q    <= '0;
    end else begin
      if (branch_evt && (perf_branches_q != '1)) begin
        perf_branches_q <= perf_branches_q + 32'd1;
      end
      if (redirect && (perf_taken_q != '1)) begin
        perf_taken_q <= perf_taken_q + 32'd1;
      end
      if (trap_take && (perf_traps_q != '1)) begin
        perf_traps_q <= perf_traps_q + 16'd1;
      end
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_taken    = perf_taken_q;
  assign perf_traps    = perf_traps_q;
`endif

  // AUIPC needs no sequencing; its result is exported combinationally
  logic unused_ok;
  assign unused_ok = is_auipc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. Two instances share
// stimulus: IALIGN=32 (main) and IALIGN=16 (JALR alignment contrast).
module tb_pc_sequencer;

  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu;
  logic        carry, zero, negative, overflow;
  logic        trap_ack;

  logic        fetch_valid, redirect, trap;
  logic [31:0] pc, link_addr, auipc_result, trap_epc;
  logic        fetch_valid16, redirect16, trap16;
  logic [31:0] pc16, link_addr16, auipc_result16, trap_epc16;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] perf_branches, perf_taken, perf_branches16, perf_taken16;
  logic [15:0] perf_traps, perf_traps16;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        trap;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer #(.IALIGN(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .pc(pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_func3(ex_func3), .ex_imm(ex_imm), .ex_alu(ex_alu),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
    .redirect(redirect), .link_addr(link_addr), .auipc_result(auipc_result),
    .trap(trap), .trap_epc(trap_epc), .trap_ack(trap_ack)
`ifdef PC_SEQ_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_taken(perf_taken), .perf_traps(perf_traps)
`endif
  );

  pc_sequencer #(.IALIGN(16)) dut16 (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid16), .fetch_ready(fetch_ready), .pc(pc16),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_func3(ex_func3), .ex_imm(ex_imm), .ex_alu(ex_alu),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
    .redirect(redirect16), .link_addr(link_addr16), .auipc_result(auipc_result16),
    .trap(trap16), .trap_epc(trap_epc16), .trap_ack(trap_ack)
`ifdef PC_SEQ_PERF_CNT_EN
    , .perf_branches(perf_branches16), .perf_taken(perf_taken16), .perf_traps(perf_traps16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] alu);
    ex_valid  = v;
    ex_opcode = op;
    ex_func3  = f3;
    ex_pc     = epc;
    ex_imm    = imm;
    ex_alu    = alu;
  endtask

  task automatic set_flags(input logic c, input logic z, input logic n, input logic v);
    carry = c; zero = z; negative = n; overflow = v;
  endtask

  // Check combinational redirect now, queue the post-edge expectation, then compare after the edge
  task automatic step(input string tag, input logic exp_redir, input logic [31:0] exp_pc,
                      input logic exp_fv, input logic exp_trap, input logic [31:0] exp_epc);
    exp_t e;
    #1;
    check({tag, ".redirect"}, 64'(redirect), 64'(exp_redir));
    e.pc = exp_pc; e.fv = exp_fv; e.trap = exp_trap; e.epc = exp_epc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      check({tag, ".pc"},          64'(pc),          64'(e.pc));
      check({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(e.fv));
      check({tag, ".trap"},        64'(trap),        64'(e.trap));
      check({tag, ".trap_epc"},    64'(trap_epc),    64'(e.epc));
    end
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b1; trap_ack = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, OP_JAL, 3'b000, 32'h10, 32'h20, 32'h0);
    #1;
    check("rst.link_addr",    64'(link_addr),    64'(32'h14));
    check("rst.auipc",        64'(auipc_result), 64'(32'h30));
    check("rst.link_addr16",  64'(link_addr16),  64'(32'h14));
    check("rst.auipc16",      64'(auipc_result16), 64'(32'h30));
    check("rst.redirect16",   64'(redirect16),   64'(0));
    step("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("reset.fv16",   64'(fetch_valid16), 64'(0));
    check("reset.trap16", 64'(trap16),        64'(0));
    check("reset.epc16",  64'(trap_epc16),    64'(0));
    check("reset.pc16",   64'(pc16),          64'(0));

    // BOOT: the JAL on ex is ignored
    rst = 1'b0;
    step("boot", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    ex_valid = 1'b0;
    step("seq4", 1'b0, 32'h4, 1'b1, 1'b0, 32'h0);
    step("seq8", 1'b0, 32'h8, 1'b1, 1'b0, 32'h0);

    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'h8, 1'b1, 1'b0, 32'h0);
    fetch_ready = 1'b1;
    step("resume", 1'b0, 32'hC, 1'b1, 1'b0, 32'h0);

    set_ex(1'b1, OP_BR, 3'b100, 32'h40, 32'h20, 32'h0);
    set_flags(1'b1, 1'b0, 1'b1, 1'b0);
    step("blt_taken", 1'b1, 32'h60, 1'b1, 1'b0, 32'h0);
    set_flags(1'b1, 1'b0, 1'b1, 1'b1);
    step("blt_nt", 1'b0, 32'h64, 1'b1, 1'b0, 32'h0);

    set_ex(1'b1, OP_BR, 3'b111, 32'h40, 32'h20, 32'h0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    step("bgeu_nt", 1'b0, 32'h68, 1'b1, 1'b0, 32'h0);
    set_ex(1'b1, OP_BR, 3'b110, 32'h10, 32'hFFFF_FFF8, 32'h0);
    step("bltu_taken", 1'b1, 32'h08, 1'b1, 1'b0, 32'h0);

    set_ex(1'b1, OP_BR, 3'b000, 32'h20, 32'h10, 32'h0);
    set_flags(1'b1, 1'b1, 1'b0, 1'b0);
    step("beq_taken", 1'b1, 32'h30, 1'b1, 1'b0, 32'h0);
    set_ex(1'b1, OP_BR, 3'b001, 32'h20, 32'h10, 32'h0);
    step("bne_nt", 1'b0, 32'h34, 1'b1, 1'b0, 32'h0);
    set_ex(1'b1, OP_BR, 3'b010, 32'h20, 32'h10, 32'h0);
    step("f3_010_nt", 1'b0, 32'h38, 1'b1, 1'b0, 32'h0);
    set_ex(1'b1, OP_BR, 3'b001, 32'h20, 32'h2, 32'h0);
    step("misalign_nt", 1'b0, 32'h3C, 1'b1, 1'b0, 32'h0);

    // Redirect wins over a stalled fetch
    fetch_ready = 1'b0;
    set_ex(1'b1, OP_JAL, 3'b000, 32'h100, 32'h100, 32'h0);
    step("jal_stall", 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);

    fetch_ready = 1'b1;
    set_ex(1'b1, OP_AUIPC, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0);
    #1;
    check("wrap.auipc", 64'(auipc_result), 64'(32'h4));
    check("wrap.link",  64'(link_addr),    64'(32'h0));
    step("auipc", 1'b0, 32'h204, 1'b1, 1'b0, 32'h0);

    // JALR 0x103: aligned to 0x102 for IALIGN=16, trap for IALIGN=32
    set_ex(1'b1, OP_JALR, 3'b000, 32'h50, 32'h0, 32'h103);
    #1;
    check("jalr.redirect16", 64'(redirect16), 64'(1));
    step("jalr_trap", 1'b0, 32'h100, 1'b0, 1'b1, 32'h50);
    check("jalr.pc16", 64'(pc16), 64'(32'h102));

    set_ex(1'b1, OP_JAL, 3'b000, 32'h0, 32'h40, 32'h0);
    step("trap_hold", 1'b0, 32'h100, 1'b0, 1'b1, 32'h50);
    ex_valid = 1'b0; trap_ack = 1'b1;
    step("trap_ack", 1'b0, 32'h100, 1'b1, 1'b0, 32'h50);
    trap_ack = 1'b0;
    step("post_trap", 1'b0, 32'h104, 1'b1, 1'b0, 32'h50);

    set_ex(1'b1, OP_JAL, 3'b000, 32'h60, 32'h6, 32'h0);
    step("jal_trap", 1'b0, 32'h100, 1'b0, 1'b1, 32'h60);
`ifdef PC_SEQ_PERF_CNT_EN
    check("perf.branches", 64'(perf_branches), 64'(8));
    check("perf.taken",    64'(perf_taken),    64'(4));
    check("perf.traps",    64'(perf_traps),    64'(2));
`endif

    // Reset in TRAP with ack and a valid aligned JAL all at once
    rst = 1'b1; trap_ack = 1'b1;
    set_ex(1'b1, OP_JAL, 3'b000, 32'h0, 32'h40, 32'h0);
    step("rst_in_trap", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef PC_SEQ_PERF_CNT_EN
    check("perf.branches_rst", 64'(perf_branches), 64'(0));
    check("perf.taken_rst",    64'(perf_taken),    64'(0));
    check("perf.traps_rst",    64'(perf_traps),    64'(0));
    check("perf16.sum_rst", 64'(perf_branches16) + 64'(perf_taken16) + 64'(perf_traps16), 64'(0));
`endif
    rst = 1'b0; trap_ack = 1'b0; ex_valid = 1'b0;
    step("reboot", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
